// File: rtl/product_accumulator.sv
// product_accumulator
//   Registered, flow-controlled sum-of-products stage behind the 3x3
//   multiplier. Products arrive over a valid/ready handshake. They are summed
//   into frames of COUNT products, or fewer when in_last ends a frame early.
//   Each frame result (sum, count, overflow) is held on a valid/ready output
//   until it is taken.
//
//   Optional build macro: ACC_SAT_EN
//     defined   - the sum clamps to 2^ACC_W-1 once it overflows and stays
//                 clamped for the rest of the frame
//     undefined - the sum wraps modulo 2^ACC_W
//   In both builds out_ovf reports that the frame overflowed.
module product_accumulator #(
  parameter int PROD_W = 7,
  parameter int ACC_W  = 9,
  parameter int COUNT  = 8,
  parameter int CNT_W  = $clog2(COUNT + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_prod,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic [CNT_W-1:0]  out_cnt,
  output logic              out_ovf
);

  typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_t;

  state_t             state;
  logic [ACC_W-1:0]   acc;
  logic [CNT_W-1:0]   cnt;
  logic               ovf;

  logic [ACC_W:0]     sum_ext;
  logic               carry;
  logic               ovf_next;
  logic [ACC_W-1:0]   acc_next;
  logic [CNT_W-1:0]   cnt_next;
  logic               xfer;
  logic               frame_end;

  // Next accumulator value for the product on the input, one bit wider to
  // catch the carry-out.
  always_comb begin
    sum_ext  = {1'b0, acc} + (ACC_W+1)'(in_prod);
    carry    = sum_ext[ACC_W];
    ovf_next = ovf | carry;
`ifdef ACC_SAT_EN
    acc_next = ovf_next ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
`else
    acc_next = sum_ext[ACC_W-1:0];
`endif
    cnt_next  = cnt + CNT_W'(1);
    xfer      = in_valid & in_ready;
    frame_end = in_last | (cnt == CNT_W'(COUNT - 1));
  end

  // Frame accumulation, result hand-off and flow control. in_ready and
  // out_valid are plain registers, so no input reaches them combinationally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ACCUM;
      acc       <= '0;
      cnt       <= '0;
      ovf       <= 1'b0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_cnt   <= '0;
      out_ovf   <= 1'b0;
    end else if (clear) begin
      // Abort: drop the partial frame and any held result. The out_* data
      // registers keep their last value because they are ignored while
      // out_valid is low.
      state     <= ACCUM;
      acc       <= '0;
      cnt       <= '0;
      ovf       <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          // This also raises in_ready on the first edge after reset.
          in_ready <= 1'b1;
          if (xfer) begin
            if (frame_end) begin
              out_sum   <= acc_next;
              out_cnt   <= cnt_next;
              out_ovf   <= ovf_next;
              out_valid <= 1'b1;
              in_ready  <= 1'b0;
              state     <= HOLD;
              acc       <= '0;
              cnt       <= '0;
              ovf       <= 1'b0;
            end else begin
              acc <= acc_next;
              cnt <= cnt_next;
              ovf <= ovf_next;
            end
          end
        end
        HOLD: begin
          // in_ready is low here, so no product can be accepted and none
          // is lost. Return to ACCUM once the result is taken.
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= ACCUM;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_product_accumulator.sv
// tb_product_accumulator
//   Drives directed frames and random traffic into two instances: the
//   default ACC_W=9 instance and an ACC_W=7 instance that overflows easily.
//   Both instances share the same inputs. The reference model keeps the
//   accepted products of the current frame in a queue. At frame end it
//   sums them with plain integer arithmetic and derives the wrap or clamp
//   result and the overflow flag from that exact total.
module tb_product_accumulator;

  localparam int COUNT = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       clear, in_valid, in_last, out_ready;
  logic [6:0] in_prod;

  logic       in_ready, out_valid, out_ovf;
  logic [8:0] out_sum;
  logic [3:0] out_cnt;
  logic       in_ready7, out_valid7, out_ovf7;
  logic [6:0] out_sum7;
  logic [3:0] out_cnt7;

  product_accumulator dut (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .in_prod(in_prod), .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cnt(out_cnt), .out_ovf(out_ovf)
  );

  product_accumulator #(.ACC_W(7)) dut7 (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready7),
    .in_prod(in_prod), .in_last(in_last), .out_valid(out_valid7), .out_ready(out_ready),
    .out_sum(out_sum7), .out_cnt(out_cnt7), .out_ovf(out_ovf7)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errs   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Reference model state
  int q[$];
  bit m_ready, m_ovalid;
  int e_cnt, e_sum9, e_ovf9, e_sum7, e_ovf7;

  // Frame result at width w, computed from the exact integer total.
  function automatic int frame_sum(input int tot, input int w);
    int mx = (1 << w) - 1;
`ifdef ACC_SAT_EN
    return (tot > mx) ? mx : tot;
`else
    return tot & mx;
`endif
  endfunction

  task automatic model_edge(input bit v, input int p, input bit l, input bit ordy, input bit clr);
    int tot;
    if (clr) begin
      q.delete();
      m_ovalid = 0;
      m_ready  = 1;
    end else if (m_ovalid) begin
      if (ordy) begin
        m_ovalid = 0;
        m_ready  = 1;
      end
    end else begin
      bit x = v && m_ready;
      m_ready = 1;
      if (x) begin
        q.push_back(p);
        if (l || q.size() == COUNT) begin
          tot = 0;
          foreach (q[i]) tot += q[i];
          e_cnt  = q.size();
          e_sum9 = frame_sum(tot, 9);
          e_ovf9 = (tot > 511) ? 1 : 0;
          e_sum7 = frame_sum(tot, 7);
          e_ovf7 = (tot > 127) ? 1 : 0;
          q.delete();
          m_ovalid = 1;
          m_ready  = 0;
        end
      end
    end
  endtask

  // One clock cycle. Entered at a negedge: drive the inputs, check the
  // outputs, step the model on the posedge, then return at the next negedge.
  task automatic cyc(input bit v, input int p, input bit l, input bit ordy, input bit clr);
    in_valid  = v;
    in_prod   = 7'(p);
    in_last   = l;
    out_ready = ordy;
    clear     = clr;
    chk("in_ready", {31'd0, in_ready}, {31'd0, m_ready});
    chk("out_valid", {31'd0, out_valid}, {31'd0, m_ovalid});
    chk("in_ready7", {31'd0, in_ready7}, {31'd0, m_ready});
    chk("out_valid7", {31'd0, out_valid7}, {31'd0, m_ovalid});
    if (m_ovalid) begin
      chk("out_sum", {23'd0, out_sum}, e_sum9);
      chk("out_cnt", {28'd0, out_cnt}, e_cnt);
      chk("out_ovf", {31'd0, out_ovf}, e_ovf9);
      chk("out_sum7", {25'd0, out_sum7}, e_sum7);
      chk("out_cnt7", {28'd0, out_cnt7}, e_cnt);
      chk("out_ovf7", {31'd0, out_ovf7}, e_ovf7);
    end
    @(posedge clk);
    model_edge(v, p, l, ordy, clr);
    @(negedge clk);
  endtask

  // Offer one product, repeating the offer until the model says it was taken.
  task automatic send(input int p, input bit l);
    int  n = 0;
    bit  done = 0;
    while (!done) begin
      done = m_ready;
      cyc(1, p, l, 1, 0);
      n++;
      if (!done && n > 20) begin
        chk("send_timeout", 0, 1);
        done = 1;
      end
    end
  endtask

  task automatic check_reset_values();
    chk("rst_in_ready", {31'd0, in_ready}, 0);
    chk("rst_out_valid", {31'd0, out_valid}, 0);
    chk("rst_out_sum", {23'd0, out_sum}, 0);
    chk("rst_out_cnt", {28'd0, out_cnt}, 0);
    chk("rst_out_ovf", {31'd0, out_ovf}, 0);
    chk("rst_out_sum7", {25'd0, out_sum7}, 0);
  endtask

  initial begin
    rst = 1; clear = 0; in_valid = 0; in_last = 0; out_ready = 0; in_prod = '0;
    m_ready = 0; m_ovalid = 0;
    e_cnt = 0; e_sum9 = 0; e_ovf9 = 0; e_sum7 = 0; e_ovf7 = 0;
    #2;
    check_reset_values();
    @(negedge clk);
    @(negedge clk);
    rst = 0;

    // Eight back-to-back products of 49: 392, count 8, no overflow.
    for (int i = 0; i < 8; i++) send(49, 0);
    cyc(1, 49, 0, 1, 0);
    cyc(0, 0, 0, 1, 0);

    // Early termination on in_last, then a full frame of 1..8.
    send(6, 0); send(12, 0); send(20, 1);
    for (int i = 1; i <= 8; i++) send(i, 0);
    cyc(0, 0, 0, 1, 0);

    // Backpressure: result held for 5 cycles while 7s are offered.
    send(5, 0); send(5, 1);
    for (int i = 0; i < 5; i++) cyc(1, 7, 0, 0, 0);
    cyc(0, 0, 0, 1, 0);
    send(3, 0); send(4, 1);
    cyc(0, 0, 0, 1, 0);

    // Four 49s: 196 fits in 9 bits, but overflows the 7-bit instance.
    for (int i = 0; i < 3; i++) send(49, 0);
    send(49, 1);
    cyc(0, 0, 0, 1, 0);

    // Clear with a concurrent valid product, then eight 1s.
    for (int i = 0; i < 3; i++) send(9, 0);
    cyc(1, 5, 0, 1, 1);
    for (int i = 0; i < 8; i++) send(1, 0);
    cyc(0, 0, 0, 1, 0);

    // Reset pulse between edges mid-frame, then a full frame of 2s.
    for (int i = 0; i < 4; i++) send(2, 0);
    rst = 1;
    #1;
    check_reset_values();
    #1;
    rst = 0;
    q.delete(); m_ready = 0; m_ovalid = 0;
    cyc(0, 0, 0, 1, 0);
    for (int i = 0; i < 8; i++) send(2, 0);
    cyc(0, 0, 0, 1, 0);

    // Random traffic with backpressure, early ends and occasional clears.
    for (int i = 0; i < 600; i++)
      cyc($urandom_range(0, 3) != 0, int'($urandom_range(0, 127)),
          $urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0,
          $urandom_range(0, 39) == 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/product_accumulator.md
Name: product_accumulator

Overview:
Downstream consumer of the 3x3 multiplier's 7-bit product stream.
- Accepts one product per cycle over a valid/ready handshake.
- Sums products into a frame of COUNT products, or fewer if terminated early by in_last.
- Presents the frame sum, product count and overflow flag on a valid/ready output held until taken.
- Gives the combinational multiplier a registered, flow-controlled sum-of-products stage (dot-product style).

Parameters:
PROD_W, 7, product width (matches 3x3 multiplier output)
ACC_W, 9, accumulator and sum width; must be >= PROD_W
COUNT, 8, products per frame; must be >= 1
CNT_W, $clog2(COUNT+1), width of the frame product counter and out_cnt

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous active-high reset
clear  input  1  synchronous frame abort, highest priority after rst
in_valid  input  1  in_prod valid
in_ready  output  1  block can accept a product this cycle
in_prod  input  PROD_W  unsigned product from multiplier
in_last  input  1  qualifies in_prod as final product of frame
out_valid  output  1  out_sum/out_cnt/out_ovf valid
out_ready  input  1  downstream accepts result
out_sum  output  ACC_W  frame sum
out_cnt  output  CNT_W  number of products in frame (1..COUNT)
out_ovf  output  1  sum exceeded 2^ACC_W-1 during frame

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values (all outputs and internal registers):
  - in_ready=0, out_valid=0, out_sum=0, out_cnt=0, out_ovf=0.
  - Internal acc=0, cnt=0, ovf=0, state=ACCUM.
  - in_ready rises on the first clk edge after rst deasserts.
- States:
  - ACCUM: in_ready=1.
  - HOLD: in_ready=0, out_valid=1.
  - in_ready and out_valid are registered; no combinational path from any input to them.
- Accept:
  - A transfer occurs on a clk edge where in_valid & in_ready.
  - acc <= acc + zero-extended in_prod, computed at ACC_W+1 bits; carry-out sets ovf (sticky for the frame).
  - cnt <= cnt+1.
  - Without a transfer, acc, cnt and ovf hold.
- Frame end: a transfer with in_last=1, or with cnt==COUNT-1, ends the frame. On that same edge:
  - out_sum <= acc+in_prod (wrapped), out_cnt <= cnt+1, out_ovf <= ovf | carry.
  - out_valid <= 1, in_ready <= 0, state <= HOLD.
  - acc, cnt, ovf <= 0.
  - Latency: result is visible the cycle after the final transfer.
- HOLD:
  - out_sum, out_cnt and out_ovf are stable while out_valid=1 and out_ready=0.
  - in_valid is ignored; no product is dropped because in_ready=0.
  - On an edge with out_ready=1: out_valid <= 0, in_ready <= 1, state <= ACCUM.
  - Minimum one-cycle bubble between frames.
- Arithmetic:
  - All values unsigned; sum wraps modulo 2^ACC_W.
  - Default worst case 8*49=392 fits in 9 bits, so out_ovf=0.
- clear=1 on an edge:
  - acc, cnt, ovf <= 0; out_valid <= 0; in_ready <= 1; state <= ACCUM.
  - Any concurrent input transfer is discarded.
  - A held result is dropped.
  - out_sum, out_cnt and out_ovf hold their last value, which is don't-care while out_valid=0.
- rst asserted mid-frame or in HOLD: immediate return to the reset values; partial sum lost.
- in_last with COUNT=1, or on the first product: frame of 1, out_cnt=1.

Optional Feature:
ACC_SAT_EN
- Defined: on carry-out, acc (and out_sum at frame end) clamps to 2^ACC_W-1 and stays clamped for the rest of the frame; out_ovf is still set.
- Undefined: modulo-2^ACC_W wrap as above; out_ovf still reports the carry.

Test Plan:
- Reset then 8 back-to-back transfers of 49 with out_ready=1 -> one cycle after 8th transfer: out_valid=1, out_sum=392, out_cnt=8, out_ovf=0; in_ready=0 for exactly that cycle.
- Products 6,12,20 with in_last on 20 -> out_sum=38, out_cnt=3; next frame 1..8 (1,2,...,8) -> out_sum=36, out_cnt=8.
- Backpressure: frame ends with out_ready=0 for 5 cycles while in_valid=1, in_prod=7 -> out_valid, out_sum and in_ready=0 stable all 5 cycles; no 7 counted in the next frame's sum.
- Override ACC_W=7, products 49,49,49,49 -> out_ovf=1; out_sum=68 (196 mod 128) without ACC_SAT_EN, 127 with ACC_SAT_EN.
- clear after 3 products of 9, asserted with a concurrent valid product 5, then 8 products of 1 -> out_sum=8, out_cnt=8.
- rst pulse (between clk edges) mid-frame after 4 products -> outputs immediately at the reset values; in_ready=0 until the first edge after release; next full frame of 2s -> out_sum=16.
